ctl_sync_requester: RTL and testbench
=====================================

// Module: ctl_sync_requester
// PURPOSE
//  Host-side initiator of the controller synchronisation handshake. Sits on the CPU-bus (BRAM port A) side.
//  On request it loads the EtherCAT sync time and the per-transducer cycle table into the controller BRAM.
//  It then sets CTL_FLAG.SYNC by read-modify-write and polls CTL_FLAG until the FPGA-side controller clears SYNC.
//  That clear marks the sync as consumed. Completion or timeout is reported to the requesting logic.
// PARAMETERS
//  WIDTH          13      cycle value width (bits); zero-extended to 16 on write
//  DEPTH          249     number of transducers / cycle entries
//  RD_LATENCY     2       port-A read latency, cycles from BUS_EN&~BUS_WE to valid BUS_DIN
//  POLL_INTERVAL  16      cycles between successive CTL_FLAG poll reads (>= RD_LATENCY+1)
//  POLL_LIMIT     65535   max poll reads before TIMEOUT_ERR
// PORTS
//  CLK          in   1          bus clock; sole clock
//  RST          in   1          asynchronous reset, active-high
//  REQ          in   1          single-cycle start pulse; ignored while BUSY
//  SYNC_TIME    in   64         EtherCAT sync time; sampled on accepted REQ
//  CYCLE        in   WIDTH[DEPTH] cycle table; must be held stable while BUSY
//  BUSY         out  1          high from cycle after accepted REQ until DONE/TIMEOUT_ERR cycle inclusive
//  DONE         out  1          1-cycle pulse: SYNC observed cleared
//  TIMEOUT_ERR  out  1          1-cycle pulse: POLL_LIMIT polls without clear
//  BUS_EN       out  1          BRAM port-A enable
//  BUS_WE       out  1          BRAM port-A write enable (valid with BUS_EN)
//  BUS_ADDR     out  11         {segment[2:0], offset[7:0]}
//  BUS_DOUT     out  16         write data
//  BUS_DIN      in   16         read data, RD_LATENCY after read issue
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE. RST mid-operation aborts at once with no further bus cycles.
//   Partially written BRAM contents are left as is; SYNC is never set by an aborted run unless its write already issued.
//  States:
//   IDLE -> WR_TIME (on REQ).
//   WR_TIME: 4 writes, EC_SYNC_TIME_0..3 = SYNC_TIME[15:0]..[63:48], one per cycle.
//   WR_CYCLE: DEPTH writes, one per cycle. Entry i goes to {BRAM_SELECT_CONTROLLER_CYCLE, 8'(i)}, data {0, CYCLE[i]}.
//   RD_FLAG: issue one read of ADDR_CTL_FLAG, then idle the bus for RD_LATENCY cycles.
//   WR_FLAG: single write of captured | (1<<CTL_FLAG_SYNC_BIT). If the captured value already has SYNC set, skip the write.
//   POLL: read CTL_FLAG once every POLL_INTERVAL cycles; the first read is POLL_INTERVAL cycles after WR_FLAG.
//    On capture with SYNC=0 -> DONE pulse -> IDLE.
//    Capture number POLL_LIMIT with SYNC=1 -> TIMEOUT_ERR pulse -> IDLE; BRAM SYNC bit left set.
//  Latency (accepted REQ at cycle 0):
//   time writes at cycles 1..4; cycle writes at cycles 5..4+DEPTH; flag read at 5+DEPTH; flag write at 6+DEPTH+RD_LATENCY.
//  Bus rules: exactly one access per BUS_EN cycle; BUS_EN=0 in every cycle without an access.
//   BUS_ADDR/BUS_DOUT may hold stale values when BUS_EN=0.
//  CTL_FLAG RMW preserves all non-SYNC bits as read. No other write to CTL_FLAG is made.
//  The controller clears SYNC only after it has consumed time and cycles, so the write ordering (time, cycle, flag) is mandatory.
//  REQ in the same cycle as DONE/TIMEOUT_ERR is ignored; REQ is accepted from IDLE only.
//  Counters: entry index 8 bit, wraps never (stops at DEPTH-1); poll counter 16 bit, saturating compare with POLL_LIMIT.
// STRUCTURE
//  Shared package (existing params header): BRAM_SELECT_CONTROLLER_MAIN/CYCLE, ADDR_CTL_FLAG, ADDR_EC_SYNC_TIME_0..3,
//   CTL_FLAG_SYNC_BIT; add req_state_t enum there for reuse by the bench monitor.
//  Sub-module: ctl_bus_reader -- issues a read, counts RD_LATENCY, presents captured word with a valid strobe.
//   Used by both RD_FLAG and POLL.
// TESTING (bench: DEPTH=4, RD_LATENCY=2, POLL_INTERVAL=16, POLL_LIMIT=8; BRAM model with scripted port-B clear)
//  1 REQ, SYNC_TIME=64'h0123_4567_89AB_CDEF, CYCLE={4096,4096,4000,1}, CTL_FLAG=16'h0005
//    -> writes 0xCDEF,0x89AB,0x4567,0x0123; then 0x1000,0x1000,0x0FA0,0x0001 at offsets 0..3 of CYCLE segment;
//    -> CTL_FLAG write at cycle 12 equals 0x0005|SYNC.
//  2 Model clears SYNC 40 cycles after flag write -> DONE pulses on first poll capture with SYNC=0; BUSY falls next cycle.
//  3 Model never clears -> exactly 8 poll reads, TIMEOUT_ERR 1-cycle pulse, no DONE, CTL_FLAG keeps SYNC set.
//  4 CTL_FLAG initially has SYNC set -> no flag write issued; polling starts; clear -> DONE.
//  5 Second REQ during WR_CYCLE, and a REQ coincident with DONE -> both ignored; bus trace identical to scenario 1.
//  6 RST asserted during WR_CYCLE entry 2 -> BUS_EN=0 same cycle (async), all outputs 0; fresh REQ runs full sequence.

Source files
------------

// File: rtl/ctl_sync_requester_pkg.sv
// ---------------------------------------------------------------------------
// ctl_sync_requester_pkg
//   Shared controller-BRAM address map and handshake definitions for the
//   host-side sync requester and anything that needs to decode its bus trace.
//   Contents: BRAM segment selects, CTL_FLAG / EC_SYNC_TIME offsets, SYNC bit
//   position and mask, requester state enum, and address/data helpers.
// ---------------------------------------------------------------------------
package ctl_sync_requester_pkg;

  // 3-bit BRAM segment selects (upper bits of the 11-bit port-A address)
  localparam logic [2:0] BRAM_SELECT_CONTROLLER_MAIN  = 3'h0;
  localparam logic [2:0] BRAM_SELECT_CONTROLLER_CYCLE = 3'h1;

  // Offsets inside the MAIN segment
  localparam logic [7:0] ADDR_CTL_FLAG         = 8'h00;
  localparam logic [7:0] ADDR_EC_SYNC_TIME_0   = 8'h10;
  localparam logic [7:0] ADDR_EC_SYNC_TIME_1   = 8'h11;
  localparam logic [7:0] ADDR_EC_SYNC_TIME_2   = 8'h12;
  localparam logic [7:0] ADDR_EC_SYNC_TIME_3   = 8'h13;

  // SYNC handshake bit inside CTL_FLAG
  localparam int          CTL_FLAG_SYNC_BIT  = 8;
  localparam logic [15:0] CTL_FLAG_SYNC_MASK = 16'h0001 << CTL_FLAG_SYNC_BIT;

  // Requester sequence states; each state names what the bus is doing now
  typedef enum logic [2:0] {
    REQ_IDLE     = 3'd0,
    REQ_WR_TIME  = 3'd1,
    REQ_WR_CYCLE = 3'd2,
    REQ_RD_FLAG  = 3'd3,
    REQ_WR_FLAG  = 3'd4,
    REQ_POLL     = 3'd5,
    REQ_FINISH   = 3'd6
  } req_state_t;

  // Full 11-bit address of a MAIN-segment register
  function automatic logic [10:0] main_addr(input logic [7:0] offset);
    return {BRAM_SELECT_CONTROLLER_MAIN, offset};
  endfunction

  // Address of sync-time word k (k = 0 holds bits [15:0])
  function automatic logic [10:0] sync_time_addr(input logic [1:0] k);
    logic [7:0] off;
    case (k)
      2'd0:    off = ADDR_EC_SYNC_TIME_0;
      2'd1:    off = ADDR_EC_SYNC_TIME_1;
      2'd2:    off = ADDR_EC_SYNC_TIME_2;
      2'd3:    off = ADDR_EC_SYNC_TIME_3;
      default: off = ADDR_EC_SYNC_TIME_0;
    endcase
    return main_addr(off);
  endfunction

  // 16-bit slice k of the 64-bit sync time
  function automatic logic [15:0] sync_time_word(input logic [63:0] t, input logic [1:0] k);
    logic [15:0] w;
    case (k)
      2'd0:    w = t[15:0];
      2'd1:    w = t[31:16];
      2'd2:    w = t[47:32];
      2'd3:    w = t[63:48];
      default: w = t[15:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ctl_sync_requester_reader.sv
// ---------------------------------------------------------------------------
// ctl_sync_requester_reader (ctl_bus_reader)
//   Tracks a port-A read from the cycle it is on the bus, counts RD_LATENCY
//   cycles and flags the cycle in which the BRAM read word is valid.
//   The word is forwarded combinationally so the requester can act on it in
//   the same cycle (keeps the flag write at read + RD_LATENCY + 1).
// Ports
//   CLK, RST      clock, asynchronous active-high reset
//   issue         a read is on the bus this cycle (BUS_EN & ~BUS_WE)
//   bus_din       BRAM port-A read data
//   rd_valid      rd_data holds the word of the tracked read this cycle
//   rd_data       captured read word
// ---------------------------------------------------------------------------
module ctl_bus_reader #(
  parameter int RD_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        issue,
  input  logic [15:0] bus_din,
  output logic        rd_valid,
  output logic [15:0] rd_data
);

  localparam int CW = $clog2(RD_LATENCY + 1);

  logic [CW-1:0] cnt_r;

  // Latency countdown: loads on issue, data is valid when it reaches one
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= CW'(0);
    end else if (issue) begin
      cnt_r <= CW'(RD_LATENCY);
    end else if (cnt_r != CW'(0)) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign rd_valid = (cnt_r == CW'(1));
  assign rd_data  = bus_din;

endmodule

// File: rtl/ctl_sync_requester.sv
// ---------------------------------------------------------------------------
// ctl_sync_requester
//   Host-side initiator of the controller sync handshake on BRAM port A.
//   On REQ: writes the 64-bit sync time (4 words), then the cycle table,
//   then read-modify-writes CTL_FLAG to set SYNC, then polls CTL_FLAG until
//   the controller clears SYNC (DONE) or the poll budget runs out
//   (TIMEOUT_ERR). Write order time -> cycles -> flag is what makes the
//   controller's consumption safe, so it is never reordered.
// Ports
//   CLK, RST           clock, asynchronous active-high reset
//   REQ                start pulse, accepted only in IDLE
//   SYNC_TIME          sync time, sampled on accepted REQ
//   CYCLE[DEPTH]       cycle table, held stable while BUSY
//   BUSY/DONE/TIMEOUT_ERR  status (DONE/TIMEOUT_ERR are 1-cycle pulses)
//   BUS_EN/WE/ADDR/DOUT    port-A request, all registered
//   BUS_DIN            port-A read data, RD_LATENCY after the read
// ---------------------------------------------------------------------------
module ctl_sync_requester
  import ctl_sync_requester_pkg::*;
#(
  parameter int WIDTH         = 13,
  parameter int DEPTH         = 249,
  parameter int RD_LATENCY    = 2,
  parameter int POLL_INTERVAL = 16,
  parameter int POLL_LIMIT    = 65535
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  input  logic [63:0]      SYNC_TIME,
  input  logic [WIDTH-1:0] CYCLE [DEPTH],
  output logic             BUSY,
  output logic             DONE,
  output logic             TIMEOUT_ERR,
  output logic             BUS_EN,
  output logic             BUS_WE,
  output logic [10:0]      BUS_ADDR,
  output logic [15:0]      BUS_DOUT,
  input  logic [15:0]      BUS_DIN
);

  // Timer is loaded one lower for the first poll because the WR_FLAG cycle
  // itself already counts towards the interval.
  localparam logic [15:0] POLL_FIRST  = 16'(POLL_INTERVAL - 2);
  localparam logic [15:0] POLL_RELOAD = 16'(POLL_INTERVAL - 1);
  localparam logic [15:0] POLL_LAST   = 16'(POLL_LIMIT - 1);
  localparam logic [7:0]  LAST_ENTRY  = 8'(DEPTH - 1);

  req_state_t  state_r, state_s;
  logic [7:0]  idx_r, idx_s;
  logic [63:0] sync_time_r, sync_time_s;
  logic [15:0] tmr_r, tmr_s;
  logic [15:0] poll_cnt_r, poll_cnt_s;
  logic        bus_en_r, bus_en_s;
  logic        bus_we_r, bus_we_s;
  logic [10:0] bus_addr_r, bus_addr_s;
  logic [15:0] bus_dout_r, bus_dout_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        timeout_r, timeout_s;

  logic [7:0]  cyc_idx_s;
  logic [15:0] cyc_word_s;
  logic        rd_valid_s;
  logic [15:0] rd_data_s;

  ctl_bus_reader #(
    .RD_LATENCY (RD_LATENCY)
  ) u_reader (
    .CLK      (CLK),
    .RST      (RST),
    .issue    (bus_en_r & ~bus_we_r),
    .bus_din  (BUS_DIN),
    .rd_valid (rd_valid_s),
    .rd_data  (rd_data_s)
  );

  // Index of the table entry carried by the next write
  always_comb begin
    cyc_idx_s = (state_r == REQ_WR_CYCLE) ? (idx_r + 8'd1) : 8'd0;
  end

  // Table lookup as a compare-mux so the 8-bit index never exceeds the table
  always_comb begin
    cyc_word_s = 16'h0000;
    for (int i = 0; i < DEPTH; i++) begin
      cyc_word_s = (cyc_idx_s == 8'(i)) ? 16'(CYCLE[i]) : cyc_word_s;
    end
  end

  // Next-state and next bus/status values; the bus outputs are registered,
  // so each state decides what the bus shows in the following cycle.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    sync_time_s = sync_time_r;
    tmr_s       = tmr_r;
    poll_cnt_s  = poll_cnt_r;
    bus_en_s    = 1'b0;
    bus_we_s    = 1'b0;
    bus_addr_s  = bus_addr_r;
    bus_dout_s  = bus_dout_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    timeout_s   = 1'b0;

    case (state_r)
      REQ_IDLE: begin
        busy_s = 1'b0;
        if (REQ) begin
          state_s     = REQ_WR_TIME;
          idx_s       = 8'd0;
          sync_time_s = SYNC_TIME;
          busy_s      = 1'b1;
          bus_en_s    = 1'b1;
          bus_we_s    = 1'b1;
          bus_addr_s  = sync_time_addr(2'd0);
          bus_dout_s  = SYNC_TIME[15:0];
        end else begin
          state_s = REQ_IDLE;
        end
      end

      REQ_WR_TIME: begin
        bus_en_s = 1'b1;
        bus_we_s = 1'b1;
        if (idx_r < 8'd3) begin
          idx_s      = idx_r + 8'd1;
          bus_addr_s = sync_time_addr(idx_s[1:0]);
          bus_dout_s = sync_time_word(sync_time_r, idx_s[1:0]);
        end else begin
          state_s    = REQ_WR_CYCLE;
          idx_s      = 8'd0;
          bus_addr_s = {BRAM_SELECT_CONTROLLER_CYCLE, 8'd0};
          bus_dout_s = cyc_word_s;
        end
      end

      REQ_WR_CYCLE: begin
        bus_en_s = 1'b1;
        if (idx_r < LAST_ENTRY) begin
          idx_s      = idx_r + 8'd1;
          bus_we_s   = 1'b1;
          bus_addr_s = {BRAM_SELECT_CONTROLLER_CYCLE, idx_s};
          bus_dout_s = cyc_word_s;
        end else begin
          // Index parks at the last entry; the flag read follows directly
          state_s    = REQ_RD_FLAG;
          bus_we_s   = 1'b0;
          bus_addr_s = main_addr(ADDR_CTL_FLAG);
        end
      end

      REQ_RD_FLAG: begin
        if (rd_valid_s) begin
          state_s = REQ_WR_FLAG;
          if (rd_data_s[CTL_FLAG_SYNC_BIT]) begin
            // SYNC already pending: leave the flag untouched, just poll
            bus_en_s = 1'b0;
          end else begin
            bus_en_s   = 1'b1;
            bus_we_s   = 1'b1;
            bus_addr_s = main_addr(ADDR_CTL_FLAG);
            bus_dout_s = rd_data_s | CTL_FLAG_SYNC_MASK;
          end
        end else begin
          state_s = REQ_RD_FLAG;
        end
      end

      REQ_WR_FLAG: begin
        state_s    = REQ_POLL;
        tmr_s      = POLL_FIRST;
        poll_cnt_s = 16'd0;
      end

      REQ_POLL: begin
        if (tmr_r == 16'd0) begin
          bus_en_s   = 1'b1;
          bus_we_s   = 1'b0;
          bus_addr_s = main_addr(ADDR_CTL_FLAG);
          tmr_s      = POLL_RELOAD;
        end else begin
          tmr_s = tmr_r - 16'd1;
        end
        // A finishing capture overrides any read the timer would start
        if (rd_valid_s) begin
          if (!rd_data_s[CTL_FLAG_SYNC_BIT]) begin
            state_s  = REQ_FINISH;
            done_s   = 1'b1;
            bus_en_s = 1'b0;
          end else if (poll_cnt_r >= POLL_LAST) begin
            state_s   = REQ_FINISH;
            timeout_s = 1'b1;
            bus_en_s  = 1'b0;
          end else begin
            poll_cnt_s = poll_cnt_r + 16'd1;
          end
        end else begin
          poll_cnt_s = poll_cnt_r;
        end
      end

      REQ_FINISH: begin
        // DONE/TIMEOUT_ERR cycle; a REQ here is deliberately dropped
        state_s = REQ_IDLE;
        busy_s  = 1'b0;
      end

      default: begin
        state_s = REQ_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Sequence registers and registered bus/status outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= REQ_IDLE;
      idx_r       <= 8'd0;
      sync_time_r <= 64'h0;
      tmr_r       <= 16'd0;
      poll_cnt_r  <= 16'd0;
      bus_en_r    <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 11'h000;
      bus_dout_r  <= 16'h0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      sync_time_r <= sync_time_s;
      tmr_r       <= tmr_s;
      poll_cnt_r  <= poll_cnt_s;
      bus_en_r    <= bus_en_s;
      bus_we_r    <= bus_we_s;
      bus_addr_r  <= bus_addr_s;
      bus_dout_r  <= bus_dout_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      timeout_r   <= timeout_s;
    end
  end

  assign BUSY        = busy_r;
  assign DONE        = done_r;
  assign TIMEOUT_ERR = timeout_r;
  assign BUS_EN      = bus_en_r;
  assign BUS_WE      = bus_we_r;
  assign BUS_ADDR    = bus_addr_r;
  assign BUS_DOUT    = bus_dout_r;

endmodule

// File: tb/tb_ctl_sync_requester.sv
// ---------------------------------------------------------------------------
// tb_ctl_sync_requester
//   Scoreboard bench: each run pushes its expected bus/status events (with the
//   cycle, relative to REQ, at which each must appear); a negedge monitor pops
//   and compares every BUS_EN / DONE / TIMEOUT_ERR cycle. A BRAM model with
//   2-cycle reads and a scripted port-B SYNC clear answers the DUT.
// ---------------------------------------------------------------------------
module tb_ctl_sync_requester;
  import ctl_sync_requester_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [10:0] FLAG_ADDR = {3'h0, 8'h00};

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic [63:0] SYNC_TIME = 64'h0;
  logic [12:0] cycle_tb [DEPTH];
  logic        BUSY, DONE, TIMEOUT_ERR, BUS_EN, BUS_WE;
  logic [10:0] BUS_ADDR;
  logic [15:0] BUS_DOUT;
  logic [15:0] BUS_DIN = 16'h0;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int t0 = 0;

  typedef struct {
    string       name;
    logic        en, we, dn, to;
    logic [10:0] addr;
    logic [15:0] data;
    int          c;
  } exp_t;
  exp_t exp_q[$];

  ctl_sync_requester #(
    .WIDTH(13), .DEPTH(DEPTH), .RD_LATENCY(2), .POLL_INTERVAL(16), .POLL_LIMIT(8)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .SYNC_TIME(SYNC_TIME), .CYCLE(cycle_tb),
    .BUSY(BUSY), .DONE(DONE), .TIMEOUT_ERR(TIMEOUT_ERR),
    .BUS_EN(BUS_EN), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_DOUT(BUS_DOUT),
    .BUS_DIN(BUS_DIN)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // BRAM model: port A writes, 2-cycle read pipeline, scripted port-B clear
  logic [15:0] mem [2048];
  logic [15:0] rd_pipe = 16'h0;
  int          clr_at = -1;
  logic        preset_req = 1'b0;
  logic [15:0] preset_val = 16'h0;
  always @(posedge CLK) begin
    if (BUS_EN && BUS_WE) mem[BUS_ADDR] <= BUS_DOUT;
    rd_pipe <= mem[BUS_ADDR];
    BUS_DIN <= rd_pipe;
    if (preset_req) mem[FLAG_ADDR] <= preset_val;
    if (clr_at >= 0 && (cyc - t0) == clr_at) mem[FLAG_ADDR] <= mem[FLAG_ADDR] & 16'hFEFF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every bus access or status pulse must match the next expectation
  always @(negedge CLK) begin
    if (!RST && (BUS_EN || DONE || TIMEOUT_ERR)) begin
      check("event_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name,
              {16'h0, BUSY, BUS_EN, BUS_WE, DONE, TIMEOUT_ERR, BUS_ADDR,
               (BUS_EN && BUS_WE) ? BUS_DOUT : 16'h0, 16'(cyc - t0)},
              {16'h0, 1'b1, e.en, e.we, e.dn, e.to, e.addr, e.data, 16'(e.c)});
      end
    end
  end

  function automatic void push_ev(input string nm, input logic en, input logic we,
                                  input logic dn, input logic to, input logic [10:0] a,
                                  input logic [15:0] d, input int c);
    exp_t e;
    e.name = nm; e.en = en; e.we = we; e.dn = dn; e.to = to;
    e.addr = a; e.data = d; e.c = c;
    exp_q.push_back(e);
  endfunction

  // Expected trace of one run; cycles hand-derived for DEPTH=4, RD_LATENCY=2
  task automatic push_run(input logic [15:0] tw [4], input logic [15:0] cw [4],
                          input logic flag_set, input int polls, input logic ends_done);
    for (int k = 0; k < 4; k++)
      push_ev("time_write", 1'b1, 1'b1, 1'b0, 1'b0, {3'h0, 8'h10 + 8'(k)}, tw[k], 1 + k);
    for (int k = 0; k < 4; k++)
      push_ev("cycle_write", 1'b1, 1'b1, 1'b0, 1'b0, {3'h1, 8'(k)}, cw[k], 5 + k);
    push_ev("flag_read", 1'b1, 1'b0, 1'b0, 1'b0, FLAG_ADDR, 16'h0, 9);
    if (!flag_set)
      push_ev("flag_write", 1'b1, 1'b1, 1'b0, 1'b0, FLAG_ADDR, 16'h0105, 12);
    for (int p = 0; p < polls; p++)
      push_ev("poll_read", 1'b1, 1'b0, 1'b0, 1'b0, FLAG_ADDR, 16'h0, 28 + 16 * p);
    push_ev(ends_done ? "done_pulse" : "timeout_pulse", 1'b0, 1'b0, ends_done, !ends_done,
            11'h000, 16'h0, 28 + 16 * (polls - 1) + 3);
  endtask

  task automatic preset_flag(input logic [15:0] v);
    @(posedge CLK); #1;
    preset_val = v; preset_req = 1'b1;
    @(posedge CLK); #1;
    preset_req = 1'b0;
  endtask

  task automatic start_run(input logic [63:0] st, input int clr);
    @(posedge CLK); #1;
    t0 = cyc; clr_at = clr; SYNC_TIME = st; REQ = 1'b1;
    @(posedge CLK); #1;
    REQ = 1'b0;
  endtask

  task automatic goto_rel(input int r);
    while ((cyc - t0) < r) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic pulse_req();
    REQ = 1'b1;
    @(posedge CLK); #1;
    REQ = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || BUSY) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(name, 64'(exp_q.size() == 0 && !BUSY), 64'd1);
  endtask

  function automatic logic [63:0] outs();
    return {35'h0, BUSY, DONE, TIMEOUT_ERR, BUS_EN, BUS_WE, BUS_ADDR, BUS_DOUT};
  endfunction

  initial begin
    logic [15:0] tw1 [4];
    logic [15:0] tw2 [4];
    logic [15:0] cw1 [4];
    logic [15:0] cw2 [4];
    tw1[0] = 16'hCDEF; tw1[1] = 16'h89AB; tw1[2] = 16'h4567; tw1[3] = 16'h0123;
    tw2[0] = 16'h3210; tw2[1] = 16'h7654; tw2[2] = 16'hBA98; tw2[3] = 16'hFEDC;
    cw1[0] = 16'h1000; cw1[1] = 16'h1000; cw1[2] = 16'h0FA0; cw1[3] = 16'h0001;
    cw2[0] = 16'h1FFF; cw2[1] = 16'h0000; cw2[2] = 16'h04D2; cw2[3] = 16'h0007;
    cycle_tb[0] = 13'd4096; cycle_tb[1] = 13'd4096; cycle_tb[2] = 13'd4000; cycle_tb[3] = 13'd1;

    // Reset state
    repeat (3) @(posedge CLK);
    #1 check("reset_outputs", outs(), 64'h0);
    @(negedge CLK) RST = 1'b0;

    // Runs 1+2: full sequence, controller clears 40 cycles after flag write
    preset_flag(16'h0005);
    push_run(tw1, cw1, 1'b0, 3, 1'b1);
    start_run(64'h0123_4567_89AB_CDEF, 52);
    goto_rel(64);
    check("busy_low_after_done", 64'(BUSY), 64'd0);
    wait_done("run_basic_complete", 50);
    for (int k = 0; k < 4; k++) begin
      check("mem_time", 64'(mem[{3'h0, 8'h10 + 8'(k)}]), 64'(tw1[k]));
      check("mem_cycle", 64'(mem[{3'h1, 8'(k)}]), 64'(cw1[k]));
    end
    check("mem_flag_cleared", 64'(mem[FLAG_ADDR]), 64'h0005);

    // Run 3: never cleared -> 8 polls then timeout, SYNC stays set
    preset_flag(16'h0005);
    push_run(tw2, cw1, 1'b0, 8, 1'b0);
    start_run(64'hFEDC_BA98_7654_3210, -1);
    wait_done("run_timeout_complete", 300);
    check("mem_flag_left_set", 64'(mem[FLAG_ADDR]), 64'h0105);

    // Run 4: SYNC already set -> no flag write, poll until cleared
    cycle_tb[0] = 13'd8191; cycle_tb[1] = 13'd0; cycle_tb[2] = 13'd1234; cycle_tb[3] = 13'd7;
    preset_flag(16'h0105);
    push_run(tw1, cw2, 1'b1, 2, 1'b1);
    start_run(64'h0123_4567_89AB_CDEF, 36);
    wait_done("run_presync_complete", 100);
    check("mem_flag_presync_cleared", 64'(mem[FLAG_ADDR]), 64'h0005);

    // Run 5: REQ during WR_CYCLE and REQ coincident with DONE are ignored
    cycle_tb[0] = 13'd4096; cycle_tb[1] = 13'd4096; cycle_tb[2] = 13'd4000; cycle_tb[3] = 13'd1;
    preset_flag(16'h0005);
    push_run(tw1, cw1, 1'b0, 3, 1'b1);
    start_run(64'h0123_4567_89AB_CDEF, 52);
    goto_rel(6);
    pulse_req();
    goto_rel(63);
    pulse_req();
    check("busy_low_after_ignored_req", 64'(BUSY), 64'd0);
    repeat (30) @(posedge CLK);
    #1 check("no_run_after_ignored_req", 64'(exp_q.size()), 64'd0);

    // Run 6: reset during cycle entry 2 aborts at once; fresh REQ runs clean
    preset_flag(16'h0005);
    push_run(tw1, cw1, 1'b0, 3, 1'b1);
    start_run(64'h0123_4567_89AB_CDEF, -1);
    goto_rel(7);
    #1 RST = 1'b1;
    #1 check("async_reset_outputs", outs(), 64'h0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    check("abort_no_sync_set", 64'(mem[FLAG_ADDR]), 64'h0005);
    push_run(tw1, cw1, 1'b0, 3, 1'b1);
    start_run(64'h0123_4567_89AB_CDEF, 52);
    wait_done("run_after_reset_complete", 100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
